// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access path:
// opcodes, sequencer state encoding and load-extension kinds.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    typedef enum logic [2:0] {
        LdByteS,
        LdByteU,
        LdHalfS,
        LdHalfU,
        LdWord
    } load_kind_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: decodes the memory opcode, checks alignment, builds byte
// enables and replicated store data, and extracts/extends load data from the bus word.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] bus_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_ext_o,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        misaligned_o
);

    load_kind_e  kind;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = bus_rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = bus_rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        is_load_o    = 1'b0;
        is_store_o   = 1'b0;
        misaligned_o = 1'b0;
        be_o         = 4'b0000;
        wdata_rep_o  = wdata_i;
        kind         = LdWord;
        case (opcode_i)
            OP_LB:  begin is_load_o = 1'b1; kind = LdByteS; end
            OP_LBU: begin is_load_o = 1'b1; kind = LdByteU; end
            OP_LH: begin
                is_load_o    = 1'b1;
                kind         = LdHalfS;
                misaligned_o = addr_lo_i[0];
            end
            OP_LHU: begin
                is_load_o    = 1'b1;
                kind         = LdHalfU;
                misaligned_o = addr_lo_i[0];
            end
            OP_LW: begin
                is_load_o    = 1'b1;
                misaligned_o = |addr_lo_i;
            end
            OP_SB: begin
                is_store_o  = 1'b1;
                be_o        = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            OP_SH: begin
                is_store_o   = 1'b1;
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o  = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            OP_SW: begin
                is_store_o   = 1'b1;
                be_o         = 4'b1111;
                misaligned_o = |addr_lo_i;
            end
            default: ;
        endcase
        // Loads always fetch the whole word; lane selection happens on return.
        if (is_load_o) begin
            be_o = 4'b1111;
        end
    end

    always_comb begin
        rdata_ext_o = bus_rdata_i;
        case (kind)
            LdByteS: rdata_ext_o = {{24{byte_sel[7]}}, byte_sel};
            LdByteU: rdata_ext_o = {24'h0, byte_sel};
            LdHalfS: rdata_ext_o = {{16{half_sel[15]}}, half_sel};
            LdHalfU: rdata_ext_o = {16'h0, half_sel};
            default: rdata_ext_o = bus_rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: accepts an aligned load/store, runs a req/ack bus
// handshake with timeout, and retires the access with a one-cycle rdata_valid pulse.
module dmem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        bus_err_q, bus_err_d;

    logic        idle;
    logic        accept;
    logic [5:0]  sel_op;
    logic [1:0]  sel_lane;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic        is_load;
    logic        is_store;
    logic        misaligned;

    // Live MEM inputs drive the lane logic only in IDLE; afterwards the latched access does.
    assign idle     = (state_q == StIdle);
    assign sel_op   = idle ? opcode : op_q;
    assign sel_lane = idle ? addr[1:0] : lane_q;

    mem_lane_align u_align (
        .opcode_i     (sel_op),
        .addr_lo_i    (sel_lane),
        .wdata_i      (wdata),
        .bus_rdata_i  (bus_rdata),
        .be_o         (be),
        .wdata_rep_o  (wdata_rep),
        .rdata_ext_o  (rdata_ext),
        .is_load_o    (is_load),
        .is_store_o   (is_store),
        .misaligned_o (misaligned)
    );

    assign accept   = idle && mem_valid && (is_load || is_store) && !misaligned;
    assign addr_err = idle && mem_valid && (is_load || is_store) && misaligned;
    assign stall    = accept || (state_q == StReq);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        lane_d        = lane_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        bus_err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d     = StReq;
                    cnt_d       = 8'd0;
                    op_d        = opcode;
                    lane_d      = addr[1:0];
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be;
                    bus_wdata_d = wdata_rep;
                end
            end
            StReq: begin
                if (bus_ack || cnt_q == TimeoutLast) begin
                    state_d       = StDone;
                    bus_req_d     = 1'b0;
                    bus_be_d      = 4'b0000;
                    rdata_valid_d = 1'b1;
                    bus_err_d     = !bus_ack;
                    rdata_d       = (bus_ack && is_load) ? rdata_ext : 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= 8'd0;
            op_q          <= 6'd0;
            lane_q        <= 2'd0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'h0;
            bus_be_q      <= 4'b0000;
            bus_wdata_q   <= 32'h0;
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            lane_q        <= lane_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, reset/back-to-back sequences and
// randomized accesses checked against a size/offset arithmetic model.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [5:0]  opcode = 6'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        addr_err;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_valid   (mem_valid),
        .opcode      (opcode),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .addr_err    (addr_err),
        .bus_err     (bus_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ack_at: REQ cycle (1-based) in which bus_ack rises; 0 means never (timeout).
    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          ack_at;
        bit          emem;
        bit          emis;
        bit          est;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    task automatic check(input string tag, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h at %0t", tag, name, act, exp, $time);
        end
    endtask

    function automatic vec_t make_vec(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [31:0] rd,
                                      input int ack_at);
        vec_t        v;
        int          size;
        int          off;
        bit          sgn;
        logic [31:0] mask;
        logic [31:0] val;
        v.op = op; v.a = a; v.wd = wd; v.rd = rd; v.ack_at = ack_at;
        v.emem = 1'b1; v.est = 1'b0; sgn = 1'b0; size = 4;
        case (op)
            6'h20: begin size = 1; sgn = 1'b1; end
            6'h21: begin size = 2; sgn = 1'b1; end
            6'h23: size = 4;
            6'h24: size = 1;
            6'h25: size = 2;
            6'h28: begin size = 1; v.est = 1'b1; end
            6'h29: begin size = 2; v.est = 1'b1; end
            6'h2b: begin size = 4; v.est = 1'b1; end
            default: v.emem = 1'b0;
        endcase
        off    = int'(a[1:0]);
        v.emis = (off % size) != 0;
        v.ebe  = v.est ? 4'(((1 << size) - 1) << off) : 4'hF;
        for (int i = 0; i < 4; i++) v.ewd[8*i +: 8] = wd[8*(i % size) +: 8];
        mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
        val  = (rd >> (8 * off)) & mask;
        if (sgn && val[8*size-1]) val = val | ~mask;
        v.erd = v.est ? 32'h0 : val;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input bit b2b, input string tag);
        int          req_cycles;
        int          exp_req;
        bit          done;
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        mem_valid = 1'b1; opcode = v.op; addr = v.a; wdata = v.wd;
        bus_rdata = v.rd; bus_ack = 1'b0;
        @(negedge clk);
        check(tag, "addr_err", addr_err, v.emem && v.emis);
        if (!v.emem || v.emis) begin
            check(tag, "stall_noop", stall, 0);
            check(tag, "req_noop", bus_req, 0);
            @(posedge clk); #1;
            mem_valid = 1'b0;
            @(negedge clk);
            check(tag, "req_after_noop", bus_req, 0);
            check(tag, "rv_after_noop", rdata_valid, 0);
            return;
        end
        check(tag, "stall_accept", stall, 1);
        check(tag, "req_accept", bus_req, 0);
        req_cycles = 0;
        done = 1'b0;
        for (int i = 1; i <= int'(TO) + 2 && !done; i++) begin
            @(posedge clk); #1;
            bus_ack = (v.ack_at > 0 && i >= v.ack_at);
            @(negedge clk);
            if (rdata_valid) begin
                done = 1'b1;
            end else begin
                req_cycles++;
                check(tag, "bus_req", bus_req, 1);
                check(tag, "stall_req", stall, 1);
                check(tag, "bus_addr", bus_addr, {v.a[31:2], 2'b00});
                check(tag, "bus_we", bus_we, v.est);
                check(tag, "bus_be", bus_be, v.ebe);
                if (v.est) check(tag, "bus_wdata", bus_wdata, v.ewd);
            end
        end
        check(tag, "done_seen", done, 1);
        exp_req = (v.ack_at > 0) ? v.ack_at : int'(TO);
        check(tag, "req_cycles", req_cycles, exp_req);
        exp_rd = (v.ack_at > 0) ? v.erd : 32'h0;
        if (done) begin
            check(tag, "stall_done", stall, 0);
            check(tag, "req_done", bus_req, 0);
            check(tag, "be_done", bus_be, 0);
            check(tag, "bus_err", bus_err, v.ack_at == 0);
            check(tag, "rdata", rdata, exp_rd);
        end
        if (b2b) return;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        bus_ack   = 1'b1;
        @(negedge clk);
        check(tag, "rv_clear", rdata_valid, 0);
        check(tag, "err_clear", bus_err, 0);
        check(tag, "req_idle", bus_req, 0);
        check(tag, "stall_idle", stall, 0);
        check(tag, "rdata_hold", rdata, exp_rd);
    endtask

    vec_t        tbl[12];
    logic [5:0]  ops[10];

    initial begin
        tbl[0]  = '{6'h28, 32'h1000_0003, 32'h0000_00A5, 32'h0, 1, 1, 0, 1,
                    4'b1000, 32'hA5A5_A5A5, 32'h0};
        tbl[1]  = '{6'h21, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 3, 1, 0, 0,
                    4'hF, 32'h0, 32'hFFFF_8001};
        tbl[2]  = '{6'h25, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 3, 1, 0, 0,
                    4'hF, 32'h0, 32'h0000_8001};
        tbl[3]  = '{6'h23, 32'h0000_2001, 32'h0, 32'h0, 1, 1, 1, 0, 4'hF, 32'h0, 32'h0};
        tbl[4]  = '{6'h29, 32'h0000_2003, 32'h0, 32'h0, 1, 1, 1, 1, 4'h0, 32'h0, 32'h0};
        tbl[5]  = '{6'h2b, 32'h0000_4004, 32'h1234_5678, 32'h0, 0, 1, 0, 1,
                    4'hF, 32'h1234_5678, 32'h0};
        tbl[6]  = '{6'h20, 32'h0000_0031, 32'h0, 32'h0000_8000, 2, 1, 0, 0,
                    4'hF, 32'h0, 32'hFFFF_FF80};
        tbl[7]  = '{6'h29, 32'h0000_0002, 32'h0000_BEEF, 32'h0, 1, 1, 0, 1,
                    4'b1100, 32'hBEEF_BEEF, 32'h0};
        tbl[8]  = '{6'h23, 32'h0000_0040, 32'h0, 32'h7654_3210, 4, 1, 0, 0,
                    4'hF, 32'h0, 32'h7654_3210};
        tbl[9]  = '{6'h0F, 32'h0000_0001, 32'h0, 32'h0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0};
        tbl[10] = '{6'h28, 32'h0000_0000, 32'h1234_5677, 32'h0, 1, 1, 0, 1,
                    4'b0001, 32'h7777_7777, 32'h0};
        tbl[11] = '{6'h25, 32'h0000_0000, 32'h0, 32'h1234_FFFE, 1, 1, 0, 0,
                    4'hF, 32'h0, 32'h0000_FFFE};
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h0F, 6'h22};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset", "stall", stall, 0);
        check("reset", "bus_req", bus_req, 0);
        check("reset", "bus_we", bus_we, 0);
        check("reset", "bus_addr", bus_addr, 0);
        check("reset", "bus_be", bus_be, 0);
        check("reset", "bus_wdata", bus_wdata, 0);
        check("reset", "rdata", rdata, 0);
        check("reset", "rdata_valid", rdata_valid, 0);
        check("reset", "bus_err", bus_err, 0);

        for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Reset during the second REQ cycle drops the access.
        @(posedge clk); #1;
        mem_valid = 1'b1; opcode = 6'h20; addr = 32'h31; bus_ack = 1'b0;
        @(negedge clk);
        check("midrst", "stall", stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst", "req1", bus_req, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst", "req2", bus_req, 1);
        @(posedge clk); #1;
        reset = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        check("midrst", "bus_req", bus_req, 0);
        check("midrst", "rdata_valid", rdata_valid, 0);
        check("midrst", "bus_be", bus_be, 0);
        check("midrst", "bus_addr", bus_addr, 0);
        check("midrst", "bus_we", bus_we, 0);
        check("midrst", "bus_wdata", bus_wdata, 0);
        check("midrst", "rdata", rdata, 0);
        check("midrst", "bus_err", bus_err, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst", "rv_later", rdata_valid, 0);
        run_vec(make_vec(6'h24, 32'h33, 32'h0, 32'h9C00_0000, 2), 1'b0, "lbu_after_rst");

        // Back-to-back: second access presented in the cycle right after DONE.
        run_vec(make_vec(6'h23, 32'h100, 32'h0, 32'hDEAD_BEEF, 1), 1'b1, "b2b_lw");
        run_vec(make_vec(6'h2b, 32'h104, 32'hCAFE_F00D, 32'h0, 2), 1'b0, "b2b_sw");

        for (int i = 0; i < 40; i++) begin
            run_vec(make_vec(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
                             int'($urandom_range(0, TO))), 1'b0, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
